// File: rtl/binact_window_reader.sv
// Circular buffer of CH-bit binary activation vectors that presents KSIZE-tap sliding windows over valid/ready.
// Optional high-water-mark output is enabled with `define BINACT_RD_HWM_EN.
module binact_window_reader #(
  parameter int CH     = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int KSIZE  = 7,
  parameter int STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         bin_in,
  input  logic                  bin_in_val,
  input  logic                  frame_clr,
  output logic [KSIZE*CH-1:0]   win_data,
  output logic                  win_val,
  input  logic                  win_rdy,
  output logic [ADDR_W:0]       fill_cnt,
  output logic                  overflow
`ifdef BINACT_RD_HWM_EN
  ,
  output logic [ADDR_W:0]       hwm
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   KSIZE_C  = (ADDR_W+1)'(KSIZE);
  localparam logic [ADDR_W:0]   STRIDE_C = (ADDR_W+1)'(STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE_P = ADDR_W'(STRIDE);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_next;
  logic [CH-1:0]       mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next, win_base;
  logic [ADDR_W:0]     room, fill_next;
  logic                hs, wr_en, drop, load_win;
  logic [KSIZE*CH-1:0] win_load;

  assign hs          = win_val & win_rdy;
  // Space freed by a same-cycle handshake is usable by a same-cycle write.
  assign room        = fill_cnt - (hs ? STRIDE_C : '0);
  assign wr_en       = bin_in_val & ~frame_clr & (room < DEPTH_C);
  assign drop        = bin_in_val & ~frame_clr & ~wr_en;
  assign fill_next   = room + {{ADDR_W{1'b0}}, wr_en};
  assign rd_ptr_next = hs ? rd_ptr + STRIDE_P : rd_ptr;
  assign win_val     = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (fill_cnt >= KSIZE_C) state_next = HOLD;
        HOLD: if (hs && fill_next < KSIZE_C) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    load_win = 1'b0;
    win_base = rd_ptr;
    if (!frame_clr) begin
      case (state)
        IDLE: load_win = (fill_cnt >= KSIZE_C);
        HOLD: begin
          load_win = hs && (fill_next >= KSIZE_C);
          win_base = rd_ptr_next;
        end
        default: load_win = 1'b0;
      endcase
    end
  end

  // A back-to-back reload can need the entry being written this cycle, so forward it.
  generate
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_tap
      logic [ADDR_W-1:0] tap_addr;
      assign tap_addr = win_base + ADDR_W'(gi);
      assign win_load[gi*CH +: CH] = (wr_en && tap_addr == wr_ptr) ? bin_in : mem[tap_addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bin_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      overflow <= 1'b0;
      win_data <= '0;
    end else if (frame_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_next;
      fill_cnt <= fill_next;
      if (drop)     overflow <= 1'b1;
      if (load_win) win_data <= win_load;
    end
  end

`ifdef BINACT_RD_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hwm <= '0;
    else if (frame_clr)      hwm <= '0;
    else if (fill_cnt > hwm) hwm <= fill_cnt;
  end
`endif

endmodule

// File: tb/tb_binact_window_reader.sv
// Directed self-checking bench for binact_window_reader (CH=32, DEPTH=64, KSIZE=7, STRIDE=1).
module tb_binact_window_reader;
  localparam int CH = 32, DEPTH = 64, ADDR_W = 6, KSIZE = 7, STRIDE = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH-1:0]       bin_in = '0;
  logic                bin_in_val = 1'b0;
  logic                frame_clr = 1'b0;
  logic [KSIZE*CH-1:0] win_data;
  logic                win_val;
  logic                win_rdy = 1'b0;
  logic [ADDR_W:0]     fill_cnt;
  logic                overflow;
`ifdef BINACT_RD_HWM_EN
  logic [ADDR_W:0]     hwm;
`endif

  int tests = 0;
  int failed = 0;

  binact_window_reader #(.CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .KSIZE(KSIZE), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_in_val(bin_in_val), .frame_clr(frame_clr),
    .win_data(win_data), .win_val(win_val), .win_rdy(win_rdy), .fill_cnt(fill_cnt),
    .overflow(overflow)
`ifdef BINACT_RD_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] tap(input int i);
    return win_data[i*CH +: CH];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    win_rdy = 1'b0; bin_in_val = 1'b0; frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests++;
    if (win_val !== 1'b0 || fill_cnt !== 7'd0 || overflow !== 1'b0 || win_data !== '0) begin
      failed++;
      $display("FAIL reset: win_val=%b fill=%0d ovf=%b data_nz=%b, required 0/0/0/0",
               win_val, fill_cnt, overflow, |win_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_window();
    win_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      bin_in = CH'(i); bin_in_val = 1'b1;
      step();
    end
    bin_in_val = 1'b0;
    tests++;
    if (win_val !== 1'b0 || fill_cnt !== 7'd7) begin
      failed++;
      $display("FAIL t1_latency: win_val=%b fill=%0d, required 0 and 7", win_val, fill_cnt);
    end
    step();
    tests++;
    if (win_val !== 1'b1 || fill_cnt !== 7'd7) begin
      failed++;
      $display("FAIL t1_valid: win_val=%b fill=%0d, required 1 and 7", win_val, fill_cnt);
    end
    for (int i = 0; i < KSIZE; i++) begin
      tests++;
      if (tap(i) !== CH'(i + 1)) begin
        failed++;
        $display("FAIL t1_tap%0d: got %h, required %h", i, tap(i), i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    win_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bin_in_val = (c < 3); bin_in = CH'(8 + c);
      step();
      for (int i = 0; i < KSIZE; i++)
        if (tap(i) !== CH'(i + 1)) bad++;
      if (win_val !== 1'b1) bad++;
    end
    bin_in_val = 1'b0;
    tests++;
    if (bad != 0 || fill_cnt !== 7'd10) begin
      failed++;
      $display("FAIL t2_stable: %0d unstable samples, fill=%0d, required 0 and 10", bad, fill_cnt);
    end
    win_rdy = 1'b1;
    step();
    win_rdy = 1'b0;
    tests++;
    if (win_val !== 1'b1 || tap(0) !== 32'h2 || tap(6) !== 32'h8 || fill_cnt !== 7'd9) begin
      failed++;
      $display("FAIL t2_next: val=%b tap0=%h tap6=%h fill=%0d, required 1/2/8/9",
               win_val, tap(0), tap(6), fill_cnt);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 65; i++) begin
      bin_in = CH'(32'h100 + i); bin_in_val = 1'b1;
      step();
      if (i == 63) begin
        tests++;
        if (fill_cnt !== 7'd64 || overflow !== 1'b0) begin
          failed++;
          $display("FAIL t3_full: fill=%0d ovf=%b, required 64 and 0", fill_cnt, overflow);
        end
      end
    end
    bin_in_val = 1'b0;
    tests++;
    if (overflow !== 1'b1 || fill_cnt !== 7'd64 || win_val !== 1'b1 ||
        tap(0) !== 32'h100 || tap(6) !== 32'h106) begin
      failed++;
      $display("FAIL t3_overflow: ovf=%b fill=%0d val=%b tap0=%h tap6=%h, required 1/64/1/100/106",
               overflow, fill_cnt, win_val, tap(0), tap(6));
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    int bad = 0;
    do_clear();
    win_rdy = 1'b1;
    for (int c = 0; c < 230; c++) begin
      bin_in_val = (c < 200); bin_in = CH'(c);
      @(negedge clk);
      if (win_val && win_rdy) begin
        bad = 0;
        for (int i = 0; i < KSIZE; i++)
          if (tap(i) !== CH'(k + i)) bad++;
        tests++;
        if (bad != 0) begin
          failed++;
          $display("FAIL t4_window%0d: tap0=%h tap6=%h, required %h and %h",
                   k, tap(0), tap(6), k, k + 6);
        end
        k++;
      end
      @(posedge clk);
      #1;
    end
    bin_in_val = 1'b0; win_rdy = 1'b0;
    tests++;
    if (k != 194 || overflow !== 1'b0 || fill_cnt !== 7'd6) begin
      failed++;
      $display("FAIL t4_count: windows=%0d ovf=%b fill=%0d, required 194/0/6", k, overflow, fill_cnt);
    end
  endtask

  task automatic test_full_handshake();
    do_clear();
    for (int i = 0; i < 64; i++) begin
      bin_in = CH'(32'h300 + i); bin_in_val = 1'b1;
      step();
    end
    tests++;
    if (fill_cnt !== 7'd64 || win_val !== 1'b1 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL t5_setup: fill=%0d val=%b ovf=%b, required 64/1/0", fill_cnt, win_val, overflow);
    end
    bin_in = 32'h3FF; bin_in_val = 1'b1; win_rdy = 1'b1;
    step();
    bin_in_val = 1'b0; win_rdy = 1'b0;
    tests++;
    if (fill_cnt !== 7'd64 || overflow !== 1'b0 || win_val !== 1'b1 ||
        tap(0) !== 32'h301 || tap(6) !== 32'h307) begin
      failed++;
      $display("FAIL t5_full_hs: fill=%0d ovf=%b val=%b tap0=%h tap6=%h, required 64/0/1/301/307",
               fill_cnt, overflow, win_val, tap(0), tap(6));
    end
  endtask

  task automatic test_frame_clr();
    frame_clr = 1'b1; bin_in_val = 1'b1; bin_in = 32'hDEAD; win_rdy = 1'b1;
    step();
    frame_clr = 1'b0; bin_in_val = 1'b0; win_rdy = 1'b0;
    tests++;
    if (win_val !== 1'b0 || fill_cnt !== 7'd0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL t6_clear: val=%b fill=%0d ovf=%b, required 0/0/0", win_val, fill_cnt, overflow);
    end
    for (int i = 0; i < 7; i++) begin
      bin_in = CH'(32'h400 + i); bin_in_val = 1'b1;
      step();
    end
    bin_in_val = 1'b0;
    step();
    tests++;
    if (win_val !== 1'b1 || tap(0) !== 32'h400 || tap(6) !== 32'h406 || fill_cnt !== 7'd7) begin
      failed++;
      $display("FAIL t6_after: val=%b tap0=%h tap6=%h fill=%0d, required 1/400/406/7",
               win_val, tap(0), tap(6), fill_cnt);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (win_val !== 1'b0 || fill_cnt !== 7'd0 || win_data !== '0) begin
      failed++;
      $display("FAIL async_reset: val=%b fill=%0d data_nz=%b, required 0/0/0",
               win_val, fill_cnt, |win_data);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_first_window();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_full_handshake();
        test_frame_clr();
        test_async_reset();
      end
      begin
        #200000;
        failed++;
        $display("FAIL timeout: bench did not complete within 200000 time units");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
